// File: rtl/game_clock_pkg.sv
// Shared types and helpers for the N-player game clock.
//   t_game_clock_state : FSM encoding exposed on o_state (IDLE=0, RUN=1, PAUSE=2, FLAG=3)
//   next_player        : round-robin successor of a player index modulo n
//   sat_add            : addition clamped to a caller-supplied maximum
package game_clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FLAG  = 2'd3
  } t_game_clock_state;

  function automatic int unsigned next_player(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

endpackage

// File: rtl/game_clock_tick.sv
// One-second tick divider for the game clock.
//   p_divider : clock cycles per tick
//   i_clk     : system clock
//   i_rst     : asynchronous active-low reset
//   i_clr     : synchronous clear of the sub-second phase (wins over i_en)
//   i_en      : count enable; the phase holds while low
//   o_tick    : high during the cycle in which the divider wraps
module game_clock_tick #(
  parameter int unsigned p_divider = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned c_cw = (p_divider > 1) ? $clog2(p_divider) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(p_divider - 1);

  logic [c_cw-1:0] cnt_q, cnt_d;

  // The wrap is combinational so the owner can apply the decrement on the same edge.
  always_comb begin
    o_tick = i_en && (cnt_q == c_last);
    cnt_d  = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + c_cw'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_clock_multi.sv
// N-player game clock core with round-robin turn passing.
//   i_clk_50m       : system clock
//   i_rst           : asynchronous active-low reset
//   i_turn_click    : per-player one-cycle click pulses
//   i_stop_click    : pause/resume toggle pulse
//   i_restart_click : return to IDLE and reload all times
//   i_init          : initial seconds loaded into every counter while in IDLE
//   o_time          : remaining seconds per player (packed array)
//   o_active        : one-hot active player, zero in IDLE
//   o_flag          : one-hot player whose time ran out
//   o_state         : FSM state encoding
//   o_tick          : pulse on each second applied in RUN
// Optional feature macro GAME_CLOCK_INCREMENT_EN: when defined, the player
// completing a turn gains p_increment seconds (saturating).
module game_clock_multi
  import game_clock_pkg::*;
#(
  parameter int unsigned p_players   = 2,
  parameter int unsigned p_width     = 8,
  parameter int unsigned p_divider   = 50_000_000,
  parameter int unsigned p_increment = 0
) (
  input  logic                              i_clk_50m,
  input  logic                              i_rst,
  input  logic [p_players-1:0]              i_turn_click,
  input  logic                              i_stop_click,
  input  logic                              i_restart_click,
  input  logic [p_width-1:0]                i_init,
  output logic [p_players-1:0][p_width-1:0] o_time,
  output logic [p_players-1:0]              o_active,
  output logic [p_players-1:0]              o_flag,
  output logic [1:0]                        o_state,
  output logic                              o_tick
);

`ifdef GAME_CLOCK_INCREMENT_EN
  localparam logic [31:0] c_time_max = 32'((2 ** p_width) - 1);
`else
  if (p_increment > 0) begin : g_inc_ignored
  end
`endif

  t_game_clock_state                 state_q, state_d;
  logic [p_players-1:0][p_width-1:0] time_q, time_d;
  logic [p_players-1:0]              active_q, active_d;
  logic [p_players-1:0]              flag_q, flag_d;
  logic                              tick_q, tick_d;

  logic        div_clr;
  logic        div_en;
  logic        div_tick;
  logic        click_found;
  logic        act_one;
  int unsigned click_idx;
  int unsigned act_idx;
  int unsigned nxt;

  game_clock_tick #(
    .p_divider(p_divider)
  ) u_tick (
    .i_clk (i_clk_50m),
    .i_rst (i_rst),
    .i_clr (div_clr),
    .i_en  (div_en),
    .o_tick(div_tick)
  );

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    active_d    = active_q;
    flag_d      = flag_q;
    tick_d      = 1'b0;
    div_clr     = 1'b0;
    div_en      = (state_q == RUN);
    nxt         = 0;

    // Lowest-index click wins when several buttons fire together.
    click_found = 1'b0;
    click_idx   = 0;
    for (int unsigned k = 0; k < p_players; k++) begin
      if (i_turn_click[k] && !click_found) begin
        click_found = 1'b1;
        click_idx   = k;
      end
    end

    act_idx = 0;
    act_one = 1'b0;
    for (int unsigned k = 0; k < p_players; k++) begin
      if (active_q[k]) begin
        act_idx = k;
        act_one = (time_q[k] == p_width'(1));
      end
    end

    case (state_q)
      IDLE: begin
        div_clr = 1'b1;
        for (int unsigned k = 0; k < p_players; k++) time_d[k] = i_init;
        if (i_init != '0 && click_found) begin
          nxt = next_player(click_idx, p_players);
          for (int unsigned k = 0; k < p_players; k++) active_d[k] = (k == nxt);
          state_d = RUN;
        end
      end
      RUN: begin
        if (div_tick) begin
          tick_d = 1'b1;
          for (int unsigned k = 0; k < p_players; k++) begin
            if (k == act_idx) time_d[k] = time_q[k] - p_width'(1);
          end
        end
        // Flag fall outranks stop, which outranks a turn pass.
        if (div_tick && act_one) begin
          state_d = FLAG;
          flag_d  = active_q;
        end else if (i_stop_click) begin
          state_d = PAUSE;
        end else if ((i_turn_click & active_q) != '0) begin
          nxt     = next_player(act_idx, p_players);
          div_clr = 1'b1;
          for (int unsigned k = 0; k < p_players; k++) active_d[k] = (k == nxt);
`ifdef GAME_CLOCK_INCREMENT_EN
          // Applied on top of any same-cycle decrement already in time_d.
          for (int unsigned k = 0; k < p_players; k++) begin
            if (k == act_idx) begin
              time_d[k] = p_width'(sat_add(32'(time_d[k]), 32'(p_increment), c_time_max));
            end
          end
`endif
        end
      end
      PAUSE: begin
        if (i_stop_click) state_d = RUN;
      end
      FLAG: begin
      end
      default: state_d = IDLE;
    endcase

    if (i_restart_click) begin
      state_d  = IDLE;
      active_d = '0;
      flag_d   = '0;
      tick_d   = 1'b0;
      div_clr  = 1'b1;
      for (int unsigned k = 0; k < p_players; k++) time_d[k] = i_init;
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      time_q   <= '0;
      active_q <= '0;
      flag_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      active_q <= active_d;
      flag_q   <= flag_d;
      tick_q   <= tick_d;
    end
  end

  assign o_time   = time_q;
  assign o_active = active_q;
  assign o_flag   = flag_q;
  assign o_state  = state_q;
  assign o_tick   = tick_q;

endmodule

// File: tb/tb_game_clock_multi.sv
// Directed bench for game_clock_multi: 3 players, 8-bit counters, 4-cycle tick.
module tb_game_clock_multi;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [2:0]       i_turn_click = '0;
  logic             i_stop_click = 1'b0;
  logic             i_restart_click = 1'b0;
  logic [7:0]       i_init = 8'd3;
  logic [2:0][7:0]  o_time;
  logic [2:0]       o_active;
  logic [2:0]       o_flag;
  logic [1:0]       o_state;
  logic             o_tick;

  int checks = 0;
  int errors = 0;

  game_clock_multi #(
    .p_players  (3),
    .p_width    (8),
    .p_divider  (4),
    .p_increment(2)
  ) dut (
    .i_clk_50m      (clk),
    .i_rst          (i_rst),
    .i_turn_click   (i_turn_click),
    .i_stop_click   (i_stop_click),
    .i_restart_click(i_restart_click),
    .i_init         (i_init),
    .o_time         (o_time),
    .o_active       (o_active),
    .o_flag         (o_flag),
    .o_state        (o_state),
    .o_tick         (o_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, sample 1 time unit later, then drop the pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    i_turn_click    = '0;
    i_stop_click    = 1'b0;
    i_restart_click = 1'b0;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 i_rst = 1'b0;
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_time", 32'(o_time), 32'h0);
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_flag", 32'(o_flag), 32'd0);
    chk("rst_tick", 32'(o_tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    cyc();
    chk("idle_load", 32'(o_time), 32'h030303);

    // Start: player 0 clicks, player 1 becomes active
    i_turn_click = 3'b001;
    cyc();
    chk("start_state", 32'(o_state), 32'd1);
    chk("start_active", 32'(o_active), 32'b010);
    chk("start_time", 32'(o_time), 32'h030303);
    repeat (3) cyc();
    chk("pre_tick", 32'(o_tick), 32'd0);
    cyc();
    chk("first_tick", 32'(o_tick), 32'd1);
    chk("first_dec", 32'(o_time[1]), 32'd2);

    // Turn passing and ignored non-active click
    i_turn_click = 3'b010;
    cyc();
    chk("pass_1to2", 32'(o_active), 32'b100);
    i_turn_click = 3'b001;
    cyc();
    chk("ignore_p0", 32'(o_active), 32'b100);
    i_turn_click = 3'b100;
    cyc();
    chk("wrap_2to0", 32'(o_active), 32'b001);

    // Player 0 runs out; active click on the flag edge is discarded
    repeat (11) cyc();
    chk("pre_flag_time", 32'(o_time[0]), 32'd1);
    i_turn_click = 3'b001;
    cyc();
    chk("flag_state", 32'(o_state), 32'd3);
    chk("flag_vec", 32'(o_flag), 32'b001);
    chk("flag_time", 32'(o_time), 32'h030200);
    chk("flag_active", 32'(o_active), 32'b001);
    i_turn_click = 3'b111;
    i_stop_click = 1'b1;
    cyc();
    cyc();
    chk("flag_hold_state", 32'(o_state), 32'd3);
    chk("flag_hold_active", 32'(o_active), 32'b001);
    chk("flag_hold_time", 32'(o_time), 32'h030200);
    chk("flag_no_tick", 32'(o_tick), 32'd0);
    i_restart_click = 1'b1;
    cyc();
    chk("restart_state", 32'(o_state), 32'd0);
    chk("restart_flag", 32'(o_flag), 32'd0);
    chk("restart_active", 32'(o_active), 32'd0);
    chk("restart_time", 32'(o_time), 32'h030303);

    // Pause preserves the sub-second phase; stop beats a same-cycle click
    i_turn_click = 3'b100;
    cyc();
    chk("start2_active", 32'(o_active), 32'b001);
    cyc();
    i_stop_click = 1'b1;
    i_turn_click = 3'b001;
    cyc();
    chk("pause_state", 32'(o_state), 32'd2);
    chk("pause_click_drop", 32'(o_active), 32'b001);
    repeat (4) cyc();
    i_turn_click = 3'b001;
    repeat (6) cyc();
    chk("pause_hold_time", 32'(o_time[0]), 32'd3);
    chk("pause_hold_active", 32'(o_active), 32'b001);
    chk("pause_no_tick", 32'(o_tick), 32'd0);
    i_stop_click = 1'b1;
    cyc();
    chk("resume_state", 32'(o_state), 32'd1);
    cyc();
    chk("resume_tick_early", 32'(o_tick), 32'd0);
    cyc();
    chk("resume_tick", 32'(o_tick), 32'd1);
    chk("resume_dec", 32'(o_time[0]), 32'd2);

    // Tick and active click in the same cycle
    i_restart_click = 1'b1;
    cyc();
    i_turn_click = 3'b001;
    cyc();
    repeat (3) cyc();
    i_turn_click = 3'b010;
    cyc();
    chk("tickclick_tick", 32'(o_tick), 32'd1);
    chk("tickclick_active", 32'(o_active), 32'b100);
`ifdef GAME_CLOCK_INCREMENT_EN
    chk("tickclick_time", 32'(o_time[1]), 32'd4);
`else
    chk("tickclick_time", 32'(o_time[1]), 32'd2);
`endif
    chk("tickclick_p0", 32'(o_time[0]), 32'd3);

    // Zero initial time: start clicks are ignored
    i_restart_click = 1'b1;
    i_init = 8'd0;
    cyc();
    i_turn_click = 3'b001;
    cyc();
    chk("zero_init_state", 32'(o_state), 32'd0);
    chk("zero_init_active", 32'(o_active), 32'd0);

    // Saturation at the top of the counter range
    i_init = 8'd255;
    cyc();
    chk("max_load", 32'(o_time), 32'hFFFFFF);
    i_turn_click = 3'b001;
    cyc();
    repeat (3) cyc();
    i_turn_click = 3'b010;
    cyc();
`ifdef GAME_CLOCK_INCREMENT_EN
    chk("sat_time", 32'(o_time[1]), 32'd255);
`else
    chk("sat_time", 32'(o_time[1]), 32'd254);
`endif
    chk("sat_active", 32'(o_active), 32'b100);

    // Asynchronous reset in the middle of RUN
    cyc();
    i_rst = 1'b0;
    #1;
    chk("async_state", 32'(o_state), 32'd0);
    chk("async_time", 32'(o_time), 32'h0);
    chk("async_active", 32'(o_active), 32'd0);
    chk("async_tick", 32'(o_tick), 32'd0);
    i_init = 8'd5;
    @(negedge clk);
    i_rst = 1'b1;
    cyc();
    chk("rerelease_state", 32'(o_state), 32'd0);
    chk("rerelease_time", 32'(o_time), 32'h050505);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
